// File: rtl/fetch_unit.sv
// Fetch front end: PC owner, instruction-memory address driver and a small
// instruction/PC queue feeding decode. Optional counters under FETCH_PERF_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QDEPTH      = 4,
  parameter int          INSTR_BYTES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_pc,
  input  logic [39:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [39:0] dec_instr,
  output logic [31:0] dec_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalled
`endif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);
  localparam logic [31:0]   PC_STEP  = 32'(INSTR_BYTES);

  logic [31:0]   pc_r;
  logic [CW-1:0] count_r;
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [39:0]   qinstr_r [QDEPTH];
  logic [31:0]   qpc_r    [QDEPTH];

  logic pop_s;
  logic push_s;
  logic full_s;

  assign full_s    = (count_r == FULL_CNT);
  assign pop_s     = dec_valid & dec_ready;
  // A full queue may still accept a fetch when the head leaves in the same cycle.
  assign push_s    = fetch_en & ~redirect_valid & (~full_s | pop_s);
  assign imem_pc   = pc_r;
  assign dec_valid = (count_r != {CW{1'b0}});
  assign dec_instr = qinstr_r[head_r];
  assign dec_pc    = qpc_r[head_r];

  // PC, queue pointers, occupancy and entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r    <= RESET_PC;
      count_r <= {CW{1'b0}};
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      for (int i = 0; i < QDEPTH; i++) begin
        qinstr_r[i] <= {40{1'b0}};
        qpc_r[i]    <= {32{1'b0}};
      end
    end else if (redirect_valid) begin
      // Flush takes priority over any same-cycle pop.
      pc_r    <= redirect_pc;
      count_r <= {CW{1'b0}};
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
    end else begin
      if (push_s) begin
        qinstr_r[tail_r] <= imem_instr;
        qpc_r[tail_r]    <= pc_r;
        tail_r           <= tail_r + {{(PW-1){1'b0}}, 1'b1};
        pc_r             <= pc_r + PC_STEP;
      end
      if (pop_s) begin
        head_r <= head_r + {{(PW-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Performance counters; survive redirects, wrap silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= 32'h0000_0000;
      perf_stalled <= 32'h0000_0000;
    end else begin
      if (push_s) begin
        perf_fetched <= perf_fetched + 32'h0000_0001;
      end
      if (fetch_en & ~redirect_valid & full_s & ~pop_s) begin
        perf_stalled <= perf_stalled + 32'h0000_0001;
      end
    end
  end
`endif

endmodule
